// File: rtl/dpi_stream_feeder.sv
// Flow-keyed front end for the regex matcher array: flow->stream table, load/char/eop sequencing, per-stream enable masks.
// Optional DPI_FEEDER_STATS_EN adds packet / eviction / drop counters.
module dpi_stream_feeder #(
  parameter int                 N_REGEX  = 8,
  parameter int                 LOAD_GAP = 2,
  parameter int                 DRAIN    = 3,
  parameter logic [N_REGEX-1:0] DEF_MASK = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [7:0]         in_data,
  input  logic [15:0]        in_flow,
  input  logic               cfg_we,
  input  logic [5:0]         cfg_stream,
  input  logic [N_REGEX-1:0] cfg_mask,
  output logic               load_state,
  output logic               new_stream_id,
  output logic [5:0]         stream_id,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic               eop,
  output logic [N_REGEX-1:0] enable,
  output logic               table_full
`ifdef DPI_FEEDER_STATS_EN
  ,
  output logic [31:0]        pkt_count,
  output logic [15:0]        evict_count,
  output logic [15:0]        drop_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP} state_t;

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic [15:0]        r_flow;
  logic [15:0]        r_key [64];
  logic [63:0]        r_valid;
  logic [N_REGEX-1:0] r_mask [64];
  logic [5:0]         r_victim;

  logic               r_load_state, r_new_stream_id, r_char_in_vld, r_eop;
  logic [5:0]         r_stream_id;
  logic [7:0]         r_char_in;
  logic [N_REGEX-1:0] r_enable;

  logic               w_hit, w_free, w_alloc, w_evict, w_drop;
  logic [5:0]         w_hit_idx, w_free_idx, w_sid;
  logic [N_REGEX-1:0] w_en_next;

  // Descending scan so the lowest matching / free index is the one kept.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (r_valid[i] && r_key[i] == r_flow) begin
        w_hit     = 1'b1;
        w_hit_idx = 6'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = 6'(i);
      end
    end
  end

  assign w_sid   = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_victim);
  assign w_alloc = (r_state == S_LOOKUP) && !w_hit;
  assign w_evict = w_alloc && !w_free;
  assign w_drop  = (r_state == S_IDLE) && in_vld && !in_sop;

  // Same-cycle cfg write to the looked-up index must be what the stream sees.
  assign w_en_next = (cfg_we && cfg_stream == w_sid) ? cfg_mask :
                     (w_hit ? r_mask[w_sid] : DEF_MASK);

  assign in_rdy        = rst_n & (w_drop | (r_state == S_STREAM));
  assign table_full    = &r_valid;
  assign load_state    = r_load_state;
  assign new_stream_id = r_new_stream_id;
  assign stream_id     = r_stream_id;
  assign char_in       = r_char_in;
  assign char_in_vld   = r_char_in_vld;
  assign eop           = r_eop;
  assign enable        = r_enable;

  // Table: cfg write is last so it wins over an allocation to the same index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_victim <= '0;
      for (int i = 0; i < 64; i++) r_mask[i] <= DEF_MASK;
    end else begin
      if (w_alloc) begin
        r_key[w_sid]   <= r_flow;
        r_valid[w_sid] <= 1'b1;
        r_mask[w_sid]  <= DEF_MASK;
        if (w_evict) r_victim <= r_victim + 6'd1;
      end
      if (cfg_we) r_mask[cfg_stream] <= cfg_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_flow          <= '0;
      r_load_state    <= 1'b0;
      r_new_stream_id <= 1'b0;
      r_stream_id     <= '0;
      r_char_in       <= '0;
      r_char_in_vld   <= 1'b0;
      r_eop           <= 1'b0;
      r_enable        <= '0;
    end else begin
      r_load_state    <= 1'b0;
      r_new_stream_id <= 1'b0;
      r_char_in_vld   <= 1'b0;
      r_eop           <= 1'b0;
      case (r_state)
        S_IDLE: if (in_vld && in_sop) begin
          r_flow  <= in_flow;
          r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_load_state    <= 1'b1;
          r_new_stream_id <= !w_hit;
          r_stream_id     <= w_sid;
          r_enable        <= w_en_next;
          r_state         <= S_LOAD;
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= (LOAD_GAP == 0) ? S_STREAM : S_GAP;
        end
        S_GAP: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(LOAD_GAP - 1)) r_state <= S_STREAM;
        end
        S_STREAM: begin
          r_char_in_vld <= in_vld;
          if (in_vld) begin
            r_char_in <= in_data;
            if (in_eop) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(DRAIN)) begin
            r_eop   <= 1'b1;
            r_state <= S_EOP;
          end
        end
        S_EOP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DPI_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count   <= '0;
      evict_count <= '0;
      drop_count  <= '0;
    end else begin
      if (r_eop)   pkt_count   <= pkt_count + 32'd1;
      if (w_evict) evict_count <= evict_count + 16'd1;
      if (w_drop)  drop_count  <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// Self-checking bench for dpi_stream_feeder: directed + randomized packets against a table/mask reference model.
module tb_dpi_stream_feeder;
  localparam int LG = 2;
  localparam int DR = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, cfg_we = 1'b0;
  logic [7:0]  in_data = '0, cfg_mask = '0;
  logic [15:0] in_flow = '0;
  logic [5:0]  cfg_stream = '0;
  logic        in_rdy, load_state, new_stream_id, char_in_vld, eop, table_full;
  logic [5:0]  stream_id;
  logic [7:0]  char_in, enable;
`ifdef DPI_FEEDER_STATS_EN
  logic [31:0] pkt_count;
  logic [15:0] evict_count, drop_count;
`endif

  dpi_stream_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .in_flow(in_flow), .cfg_we(cfg_we),
    .cfg_stream(cfg_stream), .cfg_mask(cfg_mask), .load_state(load_state),
    .new_stream_id(new_stream_id), .stream_id(stream_id), .char_in(char_in),
    .char_in_vld(char_in_vld), .eop(eop), .enable(enable), .table_full(table_full)
`ifdef DPI_FEEDER_STATS_EN
    , .pkt_count(pkt_count), .evict_count(evict_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_assert = 0, n_fail = 0;
  always @(posedge clk) cyc++;

  // Monitor: observes outputs on the falling edge.
  typedef struct { logic [5:0] sid; logic nw; logic [7:0] en; int c; } ld_t;
  ld_t        load_q[$];
  logic [7:0] got[$];
  int         last_vld_cyc = 0, eop_cnt = 0, eop_cyc = 0, first_rdy_cyc = -1;
  logic [7:0] eop_en;
  logic [5:0] eop_sid;

  always @(negedge clk) begin
    if (load_state) load_q.push_back('{stream_id, new_stream_id, enable, cyc});
    if (char_in_vld) begin got.push_back(char_in); last_vld_cyc = cyc; end
    if (eop) begin eop_cnt++; eop_cyc = cyc; eop_en = enable; eop_sid = stream_id; end
    if (in_rdy && first_rdy_cyc < 0) first_rdy_cyc = cyc;
  end

  // Reference model: associative flow table with lowest-free / round-robin victim allocation.
  logic [15:0] m_key[64];
  bit          m_val[64];
  logic [7:0]  m_mask[64];
  int          m_vict;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin m_val[i] = 0; m_mask[i] = 8'hFF; m_key[i] = '0; end
    m_vict = 0;
  endtask

  task automatic model_lookup(input logic [15:0] f, output int sid, output bit nw);
    sid = -1;
    for (int i = 0; i < 64; i++) if (sid < 0 && m_val[i] && m_key[i] == f) sid = i;
    nw = (sid < 0);
    if (nw) begin
      for (int i = 0; i < 64; i++) if (sid < 0 && !m_val[i]) sid = i;
      if (sid < 0) begin sid = m_vict; m_vict = (m_vict + 1) % 64; end
      m_key[sid] = f; m_val[sid] = 1; m_mask[sid] = 8'hFF;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input bit sop, input bit eo, input logic [15:0] f, output bit acc);
    int guard = 0;
    in_vld = 1'b1; in_sop = sop; in_eop = eo; in_data = d; in_flow = f;
    acc = 1'b0;
    while (!acc && guard < 64) begin
      @(negedge clk); acc = in_rdy;
      @(posedge clk); #1; guard++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_vld = 1'b0; cfg_we = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_pkt(input logic [15:0] flow, input int len, input bit stall,
                          input bit do_cfg, input logic [5:0] cs, input logic [7:0] cm);
    int esid, t0, guard, nmis;
    bit enew, acc;
    logic [7:0] een;
    logic [7:0] exp_b[$];
    model_lookup(flow, esid, enew);
    een = m_mask[esid];
    for (int i = 0; i < len; i++) exp_b.push_back(8'($urandom));
    @(posedge clk); #1;
    load_q.delete(); got.delete(); eop_cnt = 0; first_rdy_cyc = -1;
    t0 = cyc;
    for (int i = 0; i < len; i++) begin
      if (do_cfg && i == len - 1) begin cfg_we = 1'b1; cfg_stream = cs; cfg_mask = cm; end
      beat(exp_b[i], i == 0, i == len - 1, flow, acc);
      cfg_we = 1'b0;
      if (!acc) begin chk("accept_timeout", 0, 1); in_vld = 1'b0; return; end
      if (stall && i < len - 1) begin in_vld = 1'b0; @(posedge clk); #1; end
    end
    in_vld = 1'b0;
    if (do_cfg) m_mask[cs] = cm;
    guard = 0;
    while (eop_cnt == 0 && guard < 60) begin @(posedge clk); guard++; end
    repeat (3) @(posedge clk);
    #1;
    chk("load_count", load_q.size(), 1);
    if (load_q.size() > 0) begin
      chk("load_sid", load_q[0].sid, esid);
      chk("load_new", load_q[0].nw, enew);
      chk("load_enable", load_q[0].en, een);
      chk("load_latency", load_q[0].c - t0, 2);
    end
    chk("first_rdy_latency", first_rdy_cyc - t0, 3 + LG);
    chk("byte_count", got.size(), len);
    nmis = 0;
    for (int i = 0; i < len && i < got.size(); i++) if (got[i] !== exp_b[i]) nmis++;
    chk("byte_mismatch", nmis, 0);
    chk("eop_count", eop_cnt, 1);
    chk("eop_after_last_vld", eop_cyc - last_vld_cyc, DR + 1);
    chk("eop_enable", eop_en, een);
    chk("eop_sid", eop_sid, esid);
  endtask

  initial begin
    bit acc;
    logic [15:0] f;
    model_reset();

    // Reset state; a stray-looking beat during reset must not see in_rdy.
    in_vld = 1'b1; in_sop = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_load_state", load_state, 0);
    chk("rst_outputs", {new_stream_id, stream_id, char_in, char_in_vld, eop, enable, table_full}, 0);
    in_vld = 1'b0; rst_n = 1'b1;

    // Basic packet, repeat flow, second flow.
    send_pkt(16'h1234, 4, 0, 0, 0, 0);
    send_pkt(16'h1234, 3, 0, 0, 0, 0);
    send_pkt(16'hBEEF, 5, 0, 0, 0, 0);

    // Mask write during the active stream: visible only from the next load.
    send_pkt(16'h1234, 4, 0, 1, 6'd0, 8'h05);
    send_pkt(16'h1234, 2, 0, 0, 0, 0);

    // Randomized flows, lengths and every-other-cycle stalls.
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 2))
        0:       f = 16'h1234;
        1:       f = 16'hBEEF;
        default: f = 16'h4000 + 16'($urandom_range(0, 3));
      endcase
      send_pkt(f, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0, 0, 0);
    end
    send_pkt(16'h5555, 6, 1, 0, 0, 0);

    // Stray beats in IDLE are consumed, then a single-byte packet.
    do_reset();
    load_q.delete();
    in_vld = 1'b1; in_sop = 1'b0; in_data = 8'hAA;
    @(negedge clk); chk("stray_rdy0", in_rdy, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("stray_rdy1", in_rdy, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_no_load", load_q.size(), 0);
`ifdef DPI_FEEDER_STATS_EN
    chk("drop_count", drop_count, 2);
`endif
    send_pkt(16'h0001, 1, 0, 0, 0, 0);

    // Reset mid-packet: no eop, table cleared.
    send_pkt(16'h7777, 2, 0, 0, 0, 0);
    @(posedge clk); #1;
    beat(8'h11, 1, 0, 16'h7777, acc);
    beat(8'h22, 0, 0, 16'h7777, acc);
    chk("midpkt_accept", acc, 1);
    eop_cnt = 0;
    rst_n = 1'b0; in_vld = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_rdy", in_rdy, 0);
    chk("midrst_outputs", {load_state, stream_id, char_in_vld, enable, table_full}, 0);
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_no_eop", eop_cnt, 0);
    send_pkt(16'h7777, 2, 0, 0, 0, 0);

    // Fill the table, then two evictions in victim order.
    do_reset();
    for (int i = 0; i < 64; i++) send_pkt(16'h1000 + 16'(i), 1, 0, 0, 0, 0);
    chk("table_full", table_full, 1);
    send_pkt(16'h2000, 1, 0, 0, 0, 0);
    send_pkt(16'h2001, 2, 0, 0, 0, 0);
    send_pkt(16'h1005, 1, 0, 0, 0, 0);
`ifdef DPI_FEEDER_STATS_EN
    chk("evict_count", evict_count, 2);
    chk("pkt_count", pkt_count, 67);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
